// File: rtl/dff_bit_deserializer_if.sv
// Bit-stream in / word-stream out bundle for the flop-output deserializer.
// master = stimulus/consumer side, slave = deserializer side.
interface dff_bit_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic             bit_valid;
  logic             bit_in;
  logic             sync;
  logic             word_ready;
  logic             clr_ovf;
  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic [LW-1:0]    level;
  logic [CW-1:0]    bit_count;
  logic             overflow;

  modport master (
    output bit_valid, bit_in, sync, word_ready, clr_ovf,
    input  word_valid, word_data, level, bit_count, overflow
  );

  modport slave (
    input  bit_valid, bit_in, sync, word_ready, clr_ovf,
    output word_valid, word_data, level, bit_count, overflow
  );
endinterface

// File: rtl/dff_bit_deserializer.sv
// Serial-to-word deserializer for the D flop's dout stream. Bits are placed
// into a WIDTH-bit word, completed words land in a DEPTH-entry FIFO drained
// by a valid/ready handshake. All outputs come straight from registers.
module dff_bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input logic                   clk,
  input logic                   rst,
  dff_bit_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [WIDTH-1:0] LSB1 = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB1 = LSB1 << (WIDTH - 1);

  logic [WIDTH-1:0] sreg, base, word_nxt, head;
  logic [CW-1:0]    bcnt, idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr, rnext;
  logic [LW-1:0]    lvl;
  logic             ovf;
  logic             done, empty, full, pop, push, drop;

  // Next partial word: sync restarts from an empty word at bit position 0.
  always_comb begin
    base     = bus.sync ? '0 : sreg;
    idx      = bus.sync ? '0 : bcnt;
    word_nxt = base;
    if (bus.bit_valid && bus.bit_in)
      word_nxt = base | ((MSB_FIRST != 0) ? (MSB1 >> idx) : (LSB1 << idx));
    done  = bus.bit_valid && (idx == CW'(WIDTH - 1));
    empty = (lvl == '0);
    full  = (lvl == LW'(DEPTH));
    pop   = !empty && bus.word_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    push  = done && (!full || pop);
    drop  = done && !push;
    rnext = rptr + AW'(1);
  end

  // Partial-word shift register and bit counter; wraps to 0 on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      bcnt <= '0;
    end else if (done) begin
      sreg <= '0;
      bcnt <= '0;
    end else if (bus.bit_valid || bus.sync) begin
      sreg <= word_nxt;
      bcnt <= idx + CW'(bus.bit_valid);
    end
  end

  // FIFO storage; cleared on reset so no X can reach word_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= word_nxt;
    end
  end

  // Pointers wrap modulo DEPTH; level alone tells full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      lvl  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rnext;
      case ({push, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // Registered head word: tracks the next head, holds the last one when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
    end else if (pop) begin
      if (lvl > LW'(1))  head <= mem[rnext];
      else if (push)     head <= word_nxt;
    end else if (empty && push) begin
      head <= word_nxt;
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             ovf <= 1'b0;
    else if (drop)        ovf <= 1'b1;
    else if (bus.clr_ovf) ovf <= 1'b0;
  end

  assign bus.word_valid = !empty;
  assign bus.word_data  = head;
  assign bus.level      = lvl;
  assign bus.bit_count  = bcnt;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_dff_bit_deserializer.sv
// Randomized bench: an MSB-first and an LSB-first deserializer share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_dff_bit_deserializer;
  localparam int W = 8;
  localparam int D = 4;

  logic gclk = 1'b0;
  logic rst_n;
  always #5 gclk = ~gclk;

  dff_bit_deserializer_if #(.WIDTH(W), .DEPTH(D)) if_m ();
  dff_bit_deserializer_if #(.WIDTH(W), .DEPTH(D)) if_l ();

  dff_bit_deserializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_msb (
    .clk(gclk), .rst(rst_n), .bus(if_m)
  );
  dff_bit_deserializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) u_lsb (
    .clk(gclk), .rst(rst_n), .bus(if_l)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit           part[$];
  logic [W-1:0] fm[$];
  logic [W-1:0] fl[$];
  bit           ovf;
  logic [W-1:0] ldm, ldl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    fm.delete();
    fl.delete();
    ovf = 1'b0;
    ldm = '0;
    ldl = '0;
  endtask

  task automatic model_step(input bit bv, input bit b, input bit s, input bit rdy, input bit clr);
    bit           pop, drop;
    logic [W-1:0] wm, wl;
    pop  = (fm.size() != 0) && rdy;
    drop = 1'b0;
    if (s)  part.delete();
    if (bv) part.push_back(b);
    if (pop) begin
      fm.delete(0);
      fl.delete(0);
    end
    if (part.size() == W) begin
      wm = '0;
      wl = '0;
      for (int i = 0; i < W; i++) begin
        wm = {wm[W-2:0], part[i]};
        wl[i] = part[i];
      end
      part.delete();
      if (fm.size() < D) begin
        fm.push_back(wm);
        fl.push_back(wl);
      end else drop = 1'b1;
    end
    if (drop)     ovf = 1'b1;
    else if (clr) ovf = 1'b0;
    if (fm.size() != 0) begin
      ldm = fm[0];
      ldl = fl[0];
    end
  endtask

  task automatic compare();
    chk("m_valid", if_m.word_valid, fm.size() != 0);
    chk("m_data",  if_m.word_data,  ldm);
    chk("m_level", if_m.level,      fm.size());
    chk("m_bcnt",  if_m.bit_count,  part.size());
    chk("m_ovf",   if_m.overflow,   ovf);
    chk("l_valid", if_l.word_valid, fl.size() != 0);
    chk("l_data",  if_l.word_data,  ldl);
    chk("l_level", if_l.level,      fl.size());
    chk("l_bcnt",  if_l.bit_count,  part.size());
    chk("l_ovf",   if_l.overflow,   ovf);
  endtask

  task automatic drive(input bit bv, input bit b, input bit s, input bit rdy, input bit clr);
    if_m.bit_valid = bv;  if_l.bit_valid = bv;
    if_m.bit_in    = b;   if_l.bit_in    = b;
    if_m.sync      = s;   if_l.sync      = s;
    if_m.word_ready = rdy; if_l.word_ready = rdy;
    if_m.clr_ovf   = clr; if_l.clr_ovf   = clr;
    @(posedge gclk);
    model_step(bv, b, s, rdy, clr);
    #1;
    compare();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy);
    for (int i = W - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < D + 1; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    rst_n = 1'b0;
    model_reset();
    if_m.bit_valid = 0; if_m.bit_in = 0; if_m.sync = 0; if_m.word_ready = 0; if_m.clr_ovf = 0;
    if_l.bit_valid = 0; if_l.bit_in = 0; if_l.sync = 0; if_l.word_ready = 0; if_l.clr_ovf = 0;
    repeat (2) @(posedge gclk);
    #1;
    compare();
    rst_n = 1'b1;

    // known word 1,0,1,1,0,0,1,0
    w = 8'hB2;
    send_word(w, 1'b0);
    chk("msb_b2", if_m.word_data, 32'hB2);
    chk("lsb_4d", if_l.word_data, 32'h4D);
    drain();

    // overflow: five words into a four-deep FIFO with no consumer
    for (int k = 0; k < 5; k++) send_word(W'($urandom), 1'b0);
    chk("ovf_level", if_m.level, 32'd4);
    chk("ovf_set",   if_m.overflow, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr",   if_m.overflow, 32'd0);
    drain();

    // full FIFO, pop on the same cycle the fifth word completes
    for (int k = 0; k < 4; k++) send_word(W'($urandom), 1'b0);
    w = W'($urandom);
    for (int i = W - 1; i >= 1; i--) drive(1'b1, w[i], 1'b0, 1'b0, 1'b0);
    drive(1'b1, w[0], 1'b0, 1'b1, 1'b0);
    chk("fullpop_level", if_m.level, 32'd4);
    chk("fullpop_ovf",   if_m.overflow, 32'd0);
    drain();

    // mid-word resync
    for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_bcnt", if_m.bit_count, 32'd1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sync_m80",   if_m.word_data, 32'h80);
    chk("sync_l01",   if_l.word_data, 32'h01);
    chk("sync_level", if_m.level, 32'd1);
    drain();

    // back-to-back streaming with an always-ready consumer
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
      chk("stream_lvl", if_m.level <= 1, 32'd1);
    end
    chk("stream_ovf", if_m.overflow, 32'd0);

    // fully random traffic with one asynchronous reset in the middle
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("async_rst_data", if_m.word_data, 32'd0);
        #2 rst_n = 1'b1;
      end
      drive(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0,
            ($urandom % 3) != 0, ($urandom % 20) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
